// File: rtl/core_branch_bp_pkg.sv
// core_branch_bp_pkg: condition encodings, counter constants and counter update helper for the branch unit.
package core_branch_bp_pkg;
  typedef enum logic [2:0] {C_ALWAYS, C_NEVER, C_EQ, C_NE, C_LT, C_GE, C_LTU, C_GEU} cond_e;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  function automatic logic [1:0] cnt_upd(input logic [1:0] c, input logic up);
    return up ? ((c == 2'b11) ? c : c + 2'b01) : ((c == 2'b00) ? c : c - 2'b01);
  endfunction
endpackage

// File: rtl/core_branch_bp_if.sv
// core_branch_bp_if: issue, writeback, lookup and redirect signals of the branch unit.
interface core_branch_bp_if #(parameter int WORD_W = 32, parameter int N_REGS = 16, parameter int OFF_W = 12);
  localparam int RD_W = $clog2(N_REGS);
  logic start;
  logic [2:0] cond;
  logic indirect;
  logic writeback;
  logic [RD_W-1:0] rd;
  logic [WORD_W-2:0] pc;
  logic [OFF_W-1:0] offset;
  logic [WORD_W-1:0] a;
  logic [WORD_W-1:0] b;
  logic pred_taken;
  logic [WORD_W-2:0] pred_target;
  logic wb_stall;
  logic [WORD_W-2:0] lookup_pc;
  logic lookup_hit;
  logic lookup_taken;
  logic [WORD_W-2:0] lookup_target;
  logic wb_ready;
  logic [RD_W-1:0] wb_rd;
  logic [WORD_W-1:0] wb_value;
  logic [N_REGS-1:0] raw_mask;
  logic [WORD_W-2:0] target;
  logic redirect;
  logic stall;
  modport master(
    output start, cond, indirect, writeback, rd, pc, offset, a, b, pred_taken, pred_target, wb_stall, lookup_pc,
    input lookup_hit, lookup_taken, lookup_target, wb_ready, wb_rd, wb_value, raw_mask, target, redirect, stall
  );
  modport slave(
    input start, cond, indirect, writeback, rd, pc, offset, a, b, pred_taken, pred_target, wb_stall, lookup_pc,
    output lookup_hit, lookup_taken, lookup_target, wb_ready, wb_rd, wb_value, raw_mask, target, redirect, stall
  );
endinterface

// File: rtl/core_branch_btb.sv
// core_branch_btb: direct-mapped branch target buffer with 2-bit counters, one lookup and one update port.
module core_branch_btb import core_branch_bp_pkg::*; #(parameter int PC_W = 31, parameter int BTB_DEPTH = 16) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            lookup_hit,
  output logic            lookup_taken,
  output logic [PC_W-1:0] lookup_target,
  input  logic            upd_en,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [PC_W-1:0] upd_target
);
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = PC_W - IDX_W;
  typedef struct packed {logic valid; logic [TAG_W-1:0] tag; logic [PC_W-1:0] target; logic [1:0] cnt;} btb_entry_t;
  btb_entry_t mem_q [BTB_DEPTH];
  btb_entry_t up, up_d;
  logic [IDX_W-1:0] lk_idx, up_idx;
  logic up_hit, up_we;
  always_comb begin
    lk_idx = lookup_pc[IDX_W-1:0];
    up_idx = upd_pc[IDX_W-1:0];
    lookup_hit = mem_q[lk_idx].valid && mem_q[lk_idx].tag == lookup_pc[PC_W-1:IDX_W];
    lookup_taken = lookup_hit && mem_q[lk_idx].cnt[1];
    lookup_target = mem_q[lk_idx].target;
    up = mem_q[up_idx];
    up_hit = up.valid && up.tag == upd_pc[PC_W-1:IDX_W];
    // a not-taken miss leaves the entry alone; a taken miss allocates fresh
    up_we = upd_en && (upd_taken || up_hit);
    up_d = up_hit ? '{up.valid, up.tag, upd_taken ? upd_target : up.target, cnt_upd(up.cnt, upd_taken)}
                  : '{1'b1, upd_pc[PC_W-1:IDX_W], upd_target, WT};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < BTB_DEPTH; i++) mem_q[i] <= '{1'b0, '0, '0, WNT};
    else if (up_we) mem_q[up_idx] <= up_d;
endmodule

// File: rtl/core_raw_mask.sv
// core_raw_mask: one-hot register mask for a pending link write.
module core_raw_mask #(parameter int N_REGS = 16) (
  input  logic                      en,
  input  logic [$clog2(N_REGS)-1:0] rd,
  output logic [N_REGS-1:0]         mask
);
  assign mask = en ? N_REGS'(1) << rd : '0;
endmodule

// File: rtl/core_branch_bp.sv
// core_branch_bp: execute-stage branch resolution with BTB/counter update, link writeback and mispredict redirect.
module core_branch_bp import core_branch_bp_pkg::*; #(
  parameter int WORD_W = 32,
  parameter int N_REGS = 16,
  parameter int BTB_DEPTH = 16,
  parameter int OFF_W = 12
) (
  input logic clk,
  input logic rst_n,
  core_branch_bp_if.slave bus
);
  localparam int PC_W = WORD_W - 1;
  localparam int RD_W = $clog2(N_REGS);
  typedef struct packed {
    logic valid;
    cond_e cond;
    logic indirect;
    logic writeback;
    logic [RD_W-1:0] rd;
    logic [PC_W-1:0] pc;
    logic [OFF_W-1:0] offset;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic pred_taken;
    logic [PC_W-1:0] pred_target;
  } res_t;
  res_t r_q, r_d;
  logic taken, mispredict, live, done_q, done_d;
  logic redirect_q, redirect_d, wb_ready_q, wb_ready_d;
  logic [PC_W-1:0] res_target, nxt, target_q, target_d;
  logic [RD_W-1:0] wb_rd_q, wb_rd_d;
  logic [WORD_W-1:0] wb_value_q, wb_value_d;
  logic [N_REGS-1:0] mask_s0, mask_s1;
  always_comb begin
    r_d = bus.wb_stall ? r_q : '{bus.start, cond_e'(bus.cond), bus.indirect, bus.writeback, bus.rd, bus.pc,
                                 bus.offset, bus.a, bus.b, bus.pred_taken, bus.pred_target};
    taken = 1'b0;
    case (r_q.cond)
      C_ALWAYS: taken = 1'b1;
      C_EQ:     taken = r_q.a == r_q.b;
      C_NE:     taken = r_q.a != r_q.b;
      C_LT:     taken = $signed(r_q.a) < $signed(r_q.b);
      C_GE:     taken = $signed(r_q.a) >= $signed(r_q.b);
      C_LTU:    taken = r_q.a < r_q.b;
      C_GEU:    taken = r_q.a >= r_q.b;
      default:  taken = 1'b0;
    endcase
    res_target = r_q.indirect ? r_q.a[WORD_W-1:1] : r_q.pc + PC_W'($signed(r_q.offset));
    nxt = taken ? res_target : r_q.pc + PC_W'(1);
    mispredict = (taken != r_q.pred_taken) || (taken && res_target != r_q.pred_target);
    // a branch held in R by wb_stall redirects on its first stalled edge only
    live = r_q.valid && !done_q;
    done_d = bus.wb_stall && r_q.valid;
    redirect_d = live && mispredict;
    target_d = live ? nxt : target_q;
    wb_ready_d = bus.wb_stall ? wb_ready_q : r_q.valid && r_q.writeback;
    wb_rd_d = bus.wb_stall ? wb_rd_q : r_q.rd;
    wb_value_d = bus.wb_stall ? wb_value_q : {r_q.pc + PC_W'(1), 1'b0};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_q <= '0;
      done_q <= 1'b0;
      redirect_q <= 1'b1;
      target_q <= '0;
      wb_ready_q <= 1'b0;
      wb_rd_q <= '0;
      wb_value_q <= '0;
    end else begin
      r_q <= r_d;
      done_q <= done_d;
      redirect_q <= redirect_d;
      target_q <= target_d;
      wb_ready_q <= wb_ready_d;
      wb_rd_q <= wb_rd_d;
      wb_value_q <= wb_value_d;
    end
  core_branch_btb #(.PC_W(PC_W), .BTB_DEPTH(BTB_DEPTH)) u_btb (
    .clk(clk), .rst_n(rst_n),
    .lookup_pc(bus.lookup_pc), .lookup_hit(bus.lookup_hit), .lookup_taken(bus.lookup_taken),
    .lookup_target(bus.lookup_target),
    .upd_en(r_q.valid && !bus.wb_stall && r_q.cond != C_NEVER), .upd_taken(taken),
    .upd_pc(r_q.pc), .upd_target(res_target)
  );
  core_raw_mask #(.N_REGS(N_REGS)) u_mask_s0 (.en(bus.start && bus.writeback), .rd(bus.rd), .mask(mask_s0));
  core_raw_mask #(.N_REGS(N_REGS)) u_mask_s1 (.en(r_q.valid && r_q.writeback), .rd(r_q.rd), .mask(mask_s1));
  assign bus.raw_mask = mask_s0 | mask_s1;
  assign bus.redirect = redirect_q;
  assign bus.target = target_q;
  assign bus.wb_ready = wb_ready_q;
  assign bus.wb_rd = wb_rd_q;
  assign bus.wb_value = wb_value_q;
  assign bus.stall = (bus.start && !bus.writeback) || redirect_q;
endmodule
